// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl operation codes and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the shared datapath ALU for its additions.
// Optional build macro ALU_MUL_SEQ_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] MulA,
  input  logic [WIDTH-1:0] MulB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic             AluReq,
  input  logic             AluGnt,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluResult
);

  seq_state_e       state_r,   state_nxt_s;
  logic [WIDTH-1:0] acc_r,     acc_nxt_s;
  logic [WIDTH-1:0] mcand_r,   mcand_nxt_s;
  logic [WIDTH-1:0] mplier_r,  mplier_nxt_s;
  logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
  logic [WIDTH-1:0] product_r, product_nxt_s;

  logic [WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0] mplier_sh_s;
  logic             advance_s;
  logic             last_s;

  // Iteration datapath: an ALU add is needed only for a set multiplier bit, and that
  // iteration can complete only in a granted cycle.
  always_comb begin
    acc_step_s  = mplier_r[0] ? AluResult : acc_r;
    mplier_sh_s = mplier_r >> 1;
    advance_s   = (~mplier_r[0]) | AluGnt;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    last_s      = (cnt_r == CNT_W'(WIDTH - 1)) || (mplier_sh_s == {WIDTH{1'b0}});
`else
    last_s      = (cnt_r == CNT_W'(WIDTH - 1));
`endif
  end

  // Next-state, register updates and ALU bus drive.
  always_comb begin
    state_nxt_s   = state_r;
    acc_nxt_s     = acc_r;
    mcand_nxt_s   = mcand_r;
    mplier_nxt_s  = mplier_r;
    cnt_nxt_s     = cnt_r;
    product_nxt_s = product_r;
    AluReq        = 1'b0;
    AluA          = {WIDTH{1'b0}};
    AluB          = {WIDTH{1'b0}};
    AluCtrl       = ALU_AND;
    case (state_r)
      IDLE: begin
        if (Start) begin
          mcand_nxt_s  = MulA;
          mplier_nxt_s = MulB;
          acc_nxt_s    = {WIDTH{1'b0}};
          cnt_nxt_s    = {CNT_W{1'b0}};
          state_nxt_s  = STEP;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      STEP: begin
        if (mplier_r[0]) begin
          AluReq  = 1'b1;
          AluA    = acc_r;
          AluB    = mcand_r;
          AluCtrl = ALU_ADD;
        end else begin
          AluReq  = 1'b0;
        end
        // A stall holds every register; AluReq stays up because mplier is unchanged.
        if (advance_s) begin
          acc_nxt_s    = acc_step_s;
          mcand_nxt_s  = mcand_r << 1;
          mplier_nxt_s = mplier_sh_s;
          cnt_nxt_s    = cnt_r + CNT_W'(1);
          if (last_s) begin
            product_nxt_s = acc_step_s;
            state_nxt_s   = DONE;
          end else begin
            state_nxt_s   = STEP;
          end
        end else begin
          state_nxt_s = STEP;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r   <= IDLE;
      acc_r     <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      mcand_r   <= mcand_nxt_s;
      mplier_r  <= mplier_nxt_s;
      cnt_r     <= cnt_nxt_s;
      product_r <= product_nxt_s;
    end
  end

  assign Busy    = (state_r == STEP);
  assign Done    = (state_r == DONE);
  assign Product = product_r;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiplier sequencer that computes MUL on the shared 64-bit ALU instead of using a dedicated multiplier.
- Sits beside the datapath. It requests the ALU, drives BusA/BusB/ALUCtrl through the datapath mux while granted, and accumulates the ALU result.
- Returns the low WIDTH bits of the product using a Start/Busy/Done handshake.

Parameters:
- WIDTH, 64, operand, product and ALU bus width.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request; sampled only in IDLE
- MulA  in  WIDTH  multiplicand, captured when Start is accepted
- MulB  in  WIDTH  multiplier, captured when Start is accepted
- Busy  out  1  high from the cycle after Start is accepted until Done
- Done  out  1  one-cycle pulse; Product is valid from this cycle
- Product  out  WIDTH  low WIDTH bits of MulA*MulB; held until the next accepted Start
- AluReq  out  1  request for the shared ALU
- AluGnt  in  1  grant from the datapath; the ALU is ours only in cycles where AluReq&&AluGnt
- AluA  out  WIDTH  drives ALU BusA (accumulator)
- AluB  out  WIDTH  drives ALU BusB (shifted multiplicand)
- AluCtrl  out  4  drives ALU ALUCtrl
- AluResult  in  WIDTH  ALU BusW, sampled at the edge that ends a granted cycle

Behaviour:
- Reset: state=IDLE, Busy=0, Done=0, Product=0, AluReq=0, AluA=0, AluB=0, AluCtrl=ALU_AND. Internal acc, mcand, mplier and cnt are all 0.
- Reset mid-operation aborts immediately. No Done is issued and Product returns to 0.
- States: IDLE, STEP, DONE.
- IDLE: when Start=1, load mcand<=MulA, mplier<=MulB, acc<=0, cnt<=0, then go to STEP. Start in any other state is ignored, with no queuing.
- STEP, one iteration per completed cycle:
  - mplier[0]=0: no ALU use (AluReq=0). Shift mcand<<=1, mplier>>=1, cnt++.
  - mplier[0]=1: AluReq=1, AluA=acc, AluB=mcand, AluCtrl=ALU_ADD.
  - If AluGnt=0, stall with all registers held.
  - If AluGnt=1, acc<=AluResult and perform the same shift and cnt++ in the same edge.
  - When the iteration with cnt==WIDTH-1 completes, go to DONE.
- DONE: Product<=acc is registered on entry, so the value is visible in DONE. Done=1 and Busy=0 for one cycle, then go to IDLE. A Start asserted during DONE is ignored.
- AluReq is high only in STEP with mplier[0]=1. When AluReq=0, AluA/AluB drive 0 and AluCtrl drives ALU_AND.
- Arithmetic is modulo 2^WIDTH. Bits shifted out of mcand are discarded, and carry-out from the ALU is discarded.
- AluZero is not consumed; it is not a port.
- Latency with no grant stalls: Start is accepted at edge E0, Busy=1 at E0+1, and Done=1 in the cycle after edge E0+WIDTH, i.e. WIDTH+1 edges. Each cycle with AluReq=1 and AluGnt=0 adds exactly one cycle.
- AluGnt may toggle arbitrarily. The sequencer never drops AluReq while stalled on a set bit.

Optional Feature:
- Macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
- With the macro defined: in STEP, if mplier==0 the sequencer goes to DONE at that edge without further iterations. Latency = (index of MulB's highest set bit)+2 edges; MulB=0 gives DONE one edge after STEP entry. The result is identical.
- Without the macro: always WIDTH iterations, with fixed latency apart from grant stalls.

Decomposition:
- Package alu_pkg holds:
  - localparams for ALUCtrl codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_LSL=4'b0011, ALU_LSR=4'b0100, ALU_SUB=4'b0110, ALU_PASSB=4'b0111.
  - typedef enum for the sequencer state (IDLE, STEP, DONE).
- Single module with no sub-module. The bench instantiates the existing ALU with AluA/AluB/AluCtrl → BusA/BusB/ALUCtrl and BusW → AluResult.

Test Plan:
- MulA=3, MulB=5, AluGnt=1 → Done exactly 65 edges after the Start edge; Product=15; AluReq high in exactly 2 cycles.
- MulA=64'hFFFF_FFFF_FFFF_FFFF, MulB=2 → Product=64'hFFFF_FFFF_FFFF_FFFE.
- MulA=7, MulB=1, AluGnt held 0 for 10 cycles then 1 → AluReq stays high throughout; Done 10 cycles later than the no-stall case; Product=7.
- Start pulsed again while Busy, and in the DONE cycle → both ignored; first Product=MulA*MulB of the original operands.
- Reset=1 at iteration 20 of 6*9 → next cycle Busy=0, Product=0, AluReq=0; a new Start of 6*9 yields 54.
- With ALU_MUL_SEQ_EARLY_EXIT_EN: MulB=1 → Done 2 edges after Start; MulB=0 → Product=0, Done 2 edges after Start. Without the macro, both take 65 edges.
